// File: rtl/mix_col_pkg.sv
// GF(2^8) helpers and types shared by the MixColumns row slices.
// MIX_COL_INV_EN additionally exposes the InvMixColumns coefficient multipliers.
package mix_col_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] col_t;

  // Low byte of the AES reduction polynomial x^8+x^4+x^3+x+1.
  localparam byte_t AES_POLY_LOW = 8'h1B;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_LOW : 8'h00);
  endfunction

  function automatic byte_t mul2(input byte_t b);
    return xtime(b);
  endfunction

  function automatic byte_t mul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction

`ifdef MIX_COL_INV_EN
  function automatic byte_t mul9(input byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic byte_t mulB(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic byte_t mulD(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic byte_t mulE(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction
`endif

endpackage

// File: rtl/gf_xtime.sv
// Multiply one byte by {02} in GF(2^8); shared by all MixColumns row slices.
module gf_xtime
  import mix_col_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = xtime(in_i);

endmodule

// File: rtl/mix_col_byte3.sv
// MixColumns output row 3 for one state column, with optional output register.
// Defining MIX_COL_INV_EN adds the inv port selecting the InvMixColumns row.
module mix_col_byte3
  import mix_col_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
`ifdef MIX_COL_INV_EN
  input  logic        inv,
`endif
  input  logic [31:0] col_in,
  output logic        out_valid,
  output logic [7:0]  byte_out
);

  byte_t a [4];
  byte_t fwd_byte;
  byte_t row_byte;

  assign a[0] = col_in[31:24];
  assign a[1] = col_in[23:16];
  assign a[2] = col_in[15:8];
  assign a[3] = col_in[7:0];

`ifdef MIX_COL_INV_EN
  byte_t x1 [4];
  byte_t x2 [4];
  byte_t x3 [4];
  byte_t inv_byte;

  // Each column byte gets a three-stage xtime chain: b*{02}, b*{04}, b*{08}.
  for (genvar gi = 0; gi < 4; gi++) begin : g_chain
    gf_xtime u_x1 (.in_i(a[gi]),  .out_o(x1[gi]));
    gf_xtime u_x2 (.in_i(x1[gi]), .out_o(x2[gi]));
    gf_xtime u_x3 (.in_i(x2[gi]), .out_o(x3[gi]));
  end

  assign fwd_byte = (x1[0] ^ a[0]) ^ a[1] ^ a[2] ^ x1[3];

  // {0B}a0 ^ {0D}a1 ^ {09}a2 ^ {0E}a3 expressed as sums of the chained powers.
  assign inv_byte = (x3[0] ^ x1[0] ^ a[0])
                  ^ (x3[1] ^ x2[1] ^ a[1])
                  ^ (x3[2] ^ a[2])
                  ^ (x3[3] ^ x2[3] ^ x1[3]);

  assign row_byte = inv ? inv_byte : fwd_byte;
`else
  byte_t x1_a0;
  byte_t x1_a3;

  gf_xtime u_x1_a0 (.in_i(a[0]), .out_o(x1_a0));
  gf_xtime u_x1_a3 (.in_i(a[3]), .out_o(x1_a3));

  assign fwd_byte = (x1_a0 ^ a[0]) ^ a[1] ^ a[2] ^ x1_a3;
  assign row_byte = fwd_byte;
`endif

  if (REG_OUT) begin : g_reg
    logic  valid_q, valid_d;
    byte_t byte_q,  byte_d;

    // Result register only loads on a valid column; otherwise it holds.
    always_comb begin
      valid_d = in_valid;
      byte_d  = byte_q;
      if (in_valid) begin
        byte_d = row_byte;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        byte_q  <= 8'h00;
      end else begin
        valid_q <= valid_d;
        byte_q  <= byte_d;
      end
    end

    assign out_valid = valid_q;
    assign byte_out  = byte_q;
  end else begin : g_comb
    assign out_valid = in_valid;
    assign byte_out  = row_byte;
  end

endmodule

// File: tb/tb_mix_col_byte3.sv
// Self-checking bench for mix_col_byte3: directed vector table plus random stream
// against a generic GF(2^8) multiply model; also covers the MIX_COL_INV_EN build.
module tb_mix_col_byte3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] col_in;
  logic        out_valid;
  logic [7:0]  byte_out;
`ifdef MIX_COL_INV_EN
  logic        inv;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mix_col_byte3 #(.REG_OUT(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
`ifdef MIX_COL_INV_EN
    .inv       (inv),
`endif
    .col_in    (col_in),
    .out_valid (out_valid),
    .byte_out  (byte_out)
  );

  typedef struct {
    string       name;
    logic [31:0] col;
    logic        inv_sel;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  // Generic shift-and-add GF(2^8) product modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic [8:0] t;
    logic [7:0] aa = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ aa;
      t  = {aa, 1'b0};
      aa = t[8] ? (t[7:0] ^ 8'h1B) : t[7:0];
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_row3(input logic [31:0] c, input logic iv);
    logic [7:0] k [4];
    logic [7:0] r = 8'h00;
    if (iv) begin
      k[0] = 8'h0B; k[1] = 8'h0D; k[2] = 8'h09; k[3] = 8'h0E;
    end else begin
      k[0] = 8'h03; k[1] = 8'h01; k[2] = 8'h01; k[3] = 8'h02;
    end
    for (int i = 0; i < 4; i++) r = r ^ gmul(c[31-8*i -: 8], k[i]);
    return r;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample just after the rising edge.
  task automatic drive(input logic r, input logic v, input logic [31:0] c, input logic iv);
    rst      = r;
    in_valid = v;
    col_in   = c;
`ifdef MIX_COL_INV_EN
    inv      = iv;
`else
    if (iv) $display("note: inv requested on forward-only build");
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_v;
    logic [7:0] exp_b;
    logic       r, v, iv;
    logic [31:0] c;

    vecs.push_back('{"stream F20A225C", 32'hF20A225C, 1'b0, 8'h9D});
    vecs.push_back('{"stream 01010101", 32'h01010101, 1'b0, 8'h01});
    vecs.push_back('{"stream C6C6C6C6", 32'hC6C6C6C6, 1'b0, 8'hC6});
    vecs.push_back('{"stream D4D4D4D5", 32'hD4D4D4D5, 1'b0, 8'hD6});
    vecs.push_back('{"stream 2D26314C", 32'h2D26314C, 1'b0, 8'hF8});
    vecs.push_back('{"corner 80000000", 32'h80000000, 1'b0, 8'h9B});
    vecs.push_back('{"corner 00000080", 32'h00000080, 1'b0, 8'h1B});
    vecs.push_back('{"corner 00000000", 32'h00000000, 1'b0, 8'h00});
`ifdef MIX_COL_INV_EN
    vecs.push_back('{"inv 8E4DA1BC", 32'h8E4DA1BC, 1'b1, 8'h45});
    vecs.push_back('{"fwd 8E4DA1BC", 32'h8E4DA1BC, 1'b0, 8'h06});
    vecs.push_back('{"inv 9FDC589D", 32'h9FDC589D, 1'b1, 8'h5C});
`endif

    // Reset held with a valid column present.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'hDB135345, 1'b0);
      check("reset valid", {7'b0, out_valid}, 8'h00);
      check("reset byte", byte_out, 8'h00);
      $display("reset cycle %0d: valid=%0b byte=%02h", i, out_valid, byte_out);
    end

    drive(1'b0, 1'b1, 32'hDB135345, 1'b0);
    check("single valid", {7'b0, out_valid}, 8'h01);
    check("single byte", byte_out, 8'hBC);
    $display("single DB135345 -> valid=%0b byte=%02h", out_valid, byte_out);
    drive(1'b0, 1'b0, 32'h00000000, 1'b0);
    check("hold valid", {7'b0, out_valid}, 8'h00);
    check("hold byte", byte_out, 8'hBC);
    $display("idle -> valid=%0b byte=%02h", out_valid, byte_out);

    // Back-to-back table: each output appears one cycle after its column.
    foreach (vecs[i]) begin
      drive(1'b0, 1'b1, vecs[i].col, vecs[i].inv_sel);
      check({vecs[i].name, " valid"}, {7'b0, out_valid}, 8'h01);
      check(vecs[i].name, byte_out, vecs[i].exp);
      $display("%s -> valid=%0b byte=%02h", vecs[i].name, out_valid, byte_out);
    end

    // Reset arriving mid-stream together with a valid column.
    drive(1'b0, 1'b1, 32'hF20A225C, 1'b0);
    drive(1'b1, 1'b1, 32'h01010101, 1'b0);
    check("midrst valid", {7'b0, out_valid}, 8'h00);
    check("midrst byte", byte_out, 8'h00);
    $display("mid-stream reset -> valid=%0b byte=%02h", out_valid, byte_out);
    drive(1'b0, 1'b1, 32'hDB135345, 1'b0);
    check("post-rst valid", {7'b0, out_valid}, 8'h01);
    check("post-rst byte", byte_out, 8'hBC);
    $display("post-reset DB135345 -> valid=%0b byte=%02h", out_valid, byte_out);

    // Random stream with gaps and occasional resets against the model.
    exp_v = out_valid === 1'b1;
    exp_b = 8'hBC;
    for (int n = 0; n < 300; n++) begin
      r  = ($urandom_range(0, 31) == 0);
      v  = ($urandom_range(0, 3) != 0);
      c  = $urandom;
`ifdef MIX_COL_INV_EN
      iv = $urandom_range(0, 1) == 1;
`else
      iv = 1'b0;
`endif
      drive(r, v, c, iv);
      if (r) begin
        exp_v = 1'b0;
        exp_b = 8'h00;
      end else begin
        exp_v = v;
        if (v) exp_b = ref_row3(c, iv);
      end
      check("rand valid", {7'b0, out_valid}, {7'b0, exp_v});
      check("rand byte", byte_out, exp_b);
      $display("rand %0d: rst=%0b v=%0b col=%08h inv=%0b -> valid=%0b byte=%02h",
               n, r, v, c, iv, out_valid, byte_out);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mix_col_byte3.md
Name: mix_col_byte3

Overview:
- Computes output byte 3 (the last row) of the AES MixColumns transform for one 32-bit state column.
- Used as one of four row slices in the MixColumns datapath of the AES round.
- GF(2^8) arithmetic uses the AES polynomial x^8+x^4+x^3+x+1 (0x11B).
- The result is registered, with a one-deep valid pipeline.

Parameters:
- REG_OUT, 1, 1 = registered output (1-cycle latency); 0 = combinational byte_out and out_valid (in_valid passed through, reset has no effect).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  col_in is valid this cycle
- col_in  input  32  state column; a0=col_in[31:24], a1=[23:16], a2=[15:8], a3=[7:0]
- out_valid  output  1  byte_out is valid
- byte_out  output  8  MixColumns row-3 result

Behaviour:
- Function: byte_out = {03}·a0 ^ {01}·a1 ^ {01}·a2 ^ {02}·a3, all in GF(2^8).
- xtime(b) = (b<<1)[7:0] ^ (b[7] ? 8'h1B : 8'h00).
- {03}·b = xtime(b) ^ b.
- Combinational logic only between col_in and the output register; no multipliers or lookup tables.
- With REG_OUT=1, at each rising clk edge:
  - if rst: out_valid<=0, byte_out<=8'h00;
  - else: out_valid<=in_valid; byte_out<=f(col_in) when in_valid=1, otherwise byte_out holds its value.
- Latency is exactly 1 cycle. Back-to-back inputs are accepted every cycle; there is no backpressure.
- rst asserted mid-stream: the pending result is dropped, and outputs read 0 on the next cycle.
- rst and in_valid asserted together: rst wins.
- Output bytes are undefined from the consumer's view when out_valid=0, but must equal the held value (never X after reset).

Optional Feature:
- Macro: MIX_COL_INV_EN.
- When defined:
  - adds input port inv (1 bit), sampled alongside col_in;
  - inv=1 selects InvMixColumns row 3: byte_out = {0B}·a0 ^ {0D}·a1 ^ {09}·a2 ^ {0E}·a3, built from chained xtime;
  - inv=0 selects the forward function.
- When undefined: no inv port; forward function only.

Decomposition:
- Package mix_col_pkg holds:
  - constant AES_POLY_LOW = 8'h1B;
  - functions xtime, mul2, mul3 (and mul9/mulB/mulD/mulE under MIX_COL_INV_EN);
  - typedef byte_t (8-bit) and col_t (32-bit).
- One natural sub-module, gf_xtime (8-bit in, 8-bit out), reused by the sibling row slices.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, col_in=32'hDB135345 -> out_valid=0, byte_out=8'h00.
- Single column: col_in=32'hDB135345, in_valid=1 for one cycle -> next cycle out_valid=1, byte_out=8'hBC; following cycle out_valid=0, byte_out holds 8'hBC.
- Back-to-back stream, one column per cycle -> outputs on consecutive cycles:
  - 32'hF20A225C -> 8'h9D
  - 32'h01010101 -> 8'h01
  - 32'hC6C6C6C6 -> 8'hC6
  - 32'hD4D4D4D5 -> 8'hD6
  - 32'h2D26314C -> 8'hF8
- Reduction corner cases:
  - col_in=32'h80000000 -> 8'h9B
  - col_in=32'h00000080 -> 8'h1B
  - col_in=32'h00000000 -> 8'h00
- Reset mid-stream: stream valid columns, assert rst for one cycle -> outputs 0/0 next cycle; after rst release, 32'hDB135345 -> 8'hBC one cycle later.
- MIX_COL_INV_EN builds:
  - inv=1, col_in=32'h8E4DA1BC -> byte_out=8'h45;
  - inv=0 with the same column -> forward result for 8E4DA1BC;
  - inv=1, col_in=32'h9FDC589D -> 8'h5C.
